// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port byte memory with a
// 1-cycle synchronous read. Each transaction runs IDLE -> ISSUE -> RESP.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id,
  output logic [1:0]    fsm_state
);

  // Handshake: a requester raises reqN with we/addr/wdata/lock stable and
  // holds them until ackN pulses for one cycle; requests are sampled only in
  // IDLE, and reqN must drop or change before the edge after ackN or a second
  // transaction is issued.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);

  logic [1:0]    state;
  logic          prio;
  logic          lat_we;
  logic          lock_valid;
  logic          lock_owner;
  logic [3:0]    lock_cnt;

  logic          any_req;
  logic          owner_req;
  logic          win;
  logic          sel_we;
  logic          sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    any_req   = req0 | req1;
    owner_req = lock_owner ? req1 : req0;
    win       = 1'b0;
    if (lock_valid && owner_req) begin
      win = lock_owner;
    end else if (req0 && req1) begin
      win = prio;
    end else begin
      win = req1;
    end
    sel_we    = win ? we1    : we0;
    sel_lock  = win ? lock1  : lock0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      prio       <= 1'b0;
      lat_we     <= 1'b0;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          // An owner that stops requesting gives up its lock immediately.
          if (lock_valid && !owner_req) begin
            lock_valid <= 1'b0;
            lock_cnt   <= '0;
            prio       <= ~lock_owner;
          end
          if (any_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            grant_id  <= win;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            lat_we    <= sel_we;
            if (sel_lock) begin
              lock_valid <= 1'b1;
              lock_owner <= win;
              lock_cnt   <= (lock_valid && lock_owner == win) ? lock_cnt + 4'd1 : 4'd1;
            end else begin
              lock_valid <= 1'b0;
              lock_cnt   <= '0;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (!lat_we) begin
            rdata <= mem_rdata;
          end
          if (grant_id) begin
            ack1 <= 1'b1;
          end else begin
            ack0 <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
          // A held lock freezes priority until it is released.
          if (!lock_valid) begin
            prio <= ~grant_id;
          end else if (lock_cnt >= LOCK_LIMIT) begin
            lock_valid <= 1'b0;
            lock_cnt   <= '0;
            prio       <= ~lock_owner;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single-port transactions
// plus hand-built two-port sequences for contention, lock and reset.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy, grant_id;
  logic [1:0] fsm_state;

  logic [7:0] mem [0:255] = '{default: 8'h00};

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id), .fsm_state(fsm_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       we;
    logic       lock;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct {
    int         port;
    txn_t       t;
    logic [7:0] exp_rdata;
  } vec_t;

  // scoreboard entries: {port, is_read, expected rdata}
  logic [9:0] exp_q[$];
  txn_t       q0[$];
  txn_t       q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic lock, input logic [7:0] addr,
                              input logic [7:0] wdata);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic logic [9:0] mk_exp(input logic port, input logic is_read, input logic [7:0] d);
    return {port, is_read, d};
  endfunction

  task automatic drive_port(input int p, input logic r, input txn_t t);
    if (p == 0) begin
      req0 = r; we0 = t.we; lock0 = t.lock; addr0 = t.addr; wdata0 = t.wdata;
    end else begin
      req1 = r; we1 = t.we; lock1 = t.lock; addr1 = t.addr; wdata1 = t.wdata;
    end
  endtask

  task automatic check_ack(input logic p);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      check("extra_ack", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("ack_port", p, e[9]);
      if (e[8]) check("ack_rdata", rdata, e[7:0]);
    end
  endtask

  // Both ports present their queues from the given cycle on, re-requesting
  // back to back; acks are matched against exp_q in order.
  task automatic run_streams(input int start0, input int start1, input int budget);
    bit done = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      check("ack_overlap", ack0 & ack1, 1'b0);
      if (ack0) begin
        check_ack(1'b0);
        if (q0.size() > 0) void'(q0.pop_front());
      end
      if (ack1) begin
        check_ack(1'b1);
        if (q1.size() > 0) void'(q1.pop_front());
      end
      if (cyc >= start0 && q0.size() > 0) drive_port(0, 1'b1, q0[0]);
      else                                req0 = 1'b0;
      if (cyc >= start1 && q1.size() > 0) drive_port(1, 1'b1, q1[0]);
      else                                req1 = 1'b0;
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("stream_done", done, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id, fsm_state},
          32'd0);
  endtask

  vec_t       vecs[8];
  logic [7:0] exp_hold;

  initial begin
    // reset block
    reset = 1'b0;
    drive_port(0, 1'b0, mk(1'b0, 1'b0, 8'h00, 8'h00));
    drive_port(1, 1'b0, mk(1'b0, 1'b0, 8'h00, 8'h00));
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;
    exp_hold = 8'h00;

    vecs[0] = '{1, mk(1'b1, 1'b0, 8'h30, 8'h07), 8'h00};
    vecs[1] = '{0, mk(1'b1, 1'b0, 8'h10, 8'hA3), 8'h00};
    vecs[2] = '{0, mk(1'b0, 1'b0, 8'h10, 8'h00), 8'hA3};
    vecs[3] = '{1, mk(1'b1, 1'b0, 8'h11, 8'h3C), 8'h00};
    vecs[4] = '{1, mk(1'b0, 1'b0, 8'h11, 8'h00), 8'h3C};
    vecs[5] = '{0, mk(1'b0, 1'b0, 8'h30, 8'h00), 8'h07};
    vecs[6] = '{0, mk(1'b1, 1'b0, 8'hFF, 8'h55), 8'h00};
    vecs[7] = '{1, mk(1'b0, 1'b0, 8'hFF, 8'h00), 8'h55};

    for (int i = 0; i < 8; i++) begin
      logic pb;
      pb = (vecs[i].port == 1);
      drive_port(vecs[i].port, 1'b1, vecs[i].t);
      @(negedge clk);
      check($sformatf("vec%0d_issue", i),
            {mem_en, mem_we, mem_addr, mem_wdata, grant_id, busy, fsm_state, ack0, ack1},
            {1'b1, vecs[i].t.we, vecs[i].t.addr, vecs[i].t.wdata, pb, 1'b1, 2'd1, 2'b00});
      @(negedge clk);
      check($sformatf("vec%0d_wait", i), {mem_en, mem_we, busy, fsm_state, ack0, ack1},
            {2'b00, 1'b1, 2'd2, 2'b00});
      @(negedge clk);
      check($sformatf("vec%0d_ack", i), {ack0, ack1, busy, fsm_state}, {!pb, pb, 1'b0, 2'd0});
      if (!vecs[i].t.we) exp_hold = vecs[i].exp_rdata;
      check($sformatf("vec%0d_rdata", i), rdata, exp_hold);
      drive_port(vecs[i].port, 1'b0, vecs[i].t);
      if (vecs[i].t.we) check($sformatf("vec%0d_mem", i), mem[vecs[i].t.addr], vecs[i].t.wdata);
      @(negedge clk);
      check($sformatf("vec%0d_done", i), {ack0, ack1, busy, mem_en}, 4'b0000);
    end

    // simultaneous requests right after reset: grants alternate from port 0
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q0.push_back(mk(1'b0, 1'b0, 8'h20, 8'h00));
    q0.push_back(mk(1'b0, 1'b0, 8'h20, 8'h00));
    q1.push_back(mk(1'b1, 1'b0, 8'h20, 8'h5C));
    q1.push_back(mk(1'b1, 1'b0, 8'h20, 8'h5C));
    exp_q.push_back(mk_exp(1'b0, 1'b1, 8'h00));
    exp_q.push_back(mk_exp(1'b1, 1'b0, 8'h00));
    exp_q.push_back(mk_exp(1'b0, 1'b1, 8'h5C));
    exp_q.push_back(mk_exp(1'b1, 1'b0, 8'h00));
    run_streams(0, 0, 40);

    // lone port 0 write leaves priority with port 1
    q0.push_back(mk(1'b1, 1'b0, 8'h40, 8'h01));
    exp_q.push_back(mk_exp(1'b0, 1'b0, 8'h00));
    run_streams(0, 0, 20);

    // locked read-modify-write beats port 1 despite port 1 priority
    q0.push_back(mk(1'b0, 1'b1, 8'h30, 8'h00));
    q0.push_back(mk(1'b1, 1'b0, 8'h30, 8'h08));
    q1.push_back(mk(1'b1, 1'b0, 8'h31, 8'h99));
    exp_q.push_back(mk_exp(1'b0, 1'b1, 8'h07));
    exp_q.push_back(mk_exp(1'b0, 1'b0, 8'h00));
    exp_q.push_back(mk_exp(1'b1, 1'b0, 8'h00));
    run_streams(0, 2, 40);
    check("rmw_mem30", mem[8'h30], 8'h08);
    check("rmw_mem31", mem[8'h31], 8'h99);

    // lock starvation limit: four locked port 0 reads, then port 1
    for (int i = 0; i < 6; i++) q0.push_back(mk(1'b0, 1'b1, 8'h30, 8'h00));
    q1.push_back(mk(1'b0, 1'b0, 8'h31, 8'h00));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk_exp(1'b0, 1'b1, 8'h08));
    exp_q.push_back(mk_exp(1'b1, 1'b1, 8'h99));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk_exp(1'b0, 1'b1, 8'h08));
    run_streams(0, 2, 60);
    repeat (2) @(negedge clk);

    // reset lands on the RESP edge of a port 1 read
    drive_port(1, 1'b1, mk(1'b0, 1'b0, 8'h31, 8'h00));
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_state", fsm_state, 2'd2);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset_outputs");
    req1 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_no_ack", {ack0, ack1}, 2'b00);
    q0.push_back(mk(1'b0, 1'b0, 8'h31, 8'h00));
    q1.push_back(mk(1'b0, 1'b0, 8'h30, 8'h00));
    exp_q.push_back(mk_exp(1'b0, 1'b1, 8'h99));
    exp_q.push_back(mk_exp(1'b1, 1'b1, 8'h08));
    run_streams(0, 0, 30);

    // idle for ten cycles, then a port 1 write at the top of memory
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), {busy, mem_en, ack0, ack1}, 4'b0000);
    end
    q1.push_back(mk(1'b1, 1'b0, 8'hFE, 8'hFF));
    exp_q.push_back(mk_exp(1'b1, 1'b0, 8'h00));
    run_streams(0, 0, 20);
    check("idle_write_mem", mem[8'hFE], 8'hFF);
    check("idle_write_grant", grant_id, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
